// File: rtl/miniRISC_pkg.sv
// Shared definitions for the miniRISC fetch path: datapath width and the
// fetch sequencer state encoding.
package miniRISC_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/pc_register.sv
// Word-wide register with synchronous active-high reset to a fixed value
// and a load enable; used to hold the program counter.
module pc_register
    import miniRISC_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction fetch sequencer for the miniRISC core.
// The next-PC mux lives outside: npc_plus4 feeds its ZERO leg, next_pc is its output.
module pc_fetch_sequencer
    import miniRISC_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WORD_W-1:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] npc_plus4,
    input  logic [WORD_W-1:0] next_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_accept,
    input  logic              halt,
    output logic              halted,
    output logic              misalign,
    output logic [WORD_W-1:0] fetch_count,
    output logic [1:0]        fsm_state
);

    // Handshakes: a fetch completes on a cycle with imem_req && imem_rdy; a word
    // is handed to decode on a cycle with instr_valid && instr_accept. imem_rdy
    // outside REQ and instr_accept outside HOLD have no effect.
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WORD_W-1:0] pc;
    logic              pc_load;

    assign pc_load = (state == ST_HOLD) && instr_accept;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = halt ? ST_HALTED : ST_REQ;
            ST_REQ:    if (imem_rdy) state_nxt = ST_HOLD;
            ST_HOLD:   if (instr_accept) state_nxt = halt ? ST_HALTED : ST_REQ;
            ST_HALTED: if (!halt) state_nxt = ST_REQ;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr       <= '0;
            fetch_count <= '0;
            misalign    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_REQ) && imem_rdy) begin
                instr <= imem_data;
            end
            if (pc_load) begin
                fetch_count <= fetch_count + 1'b1;
                misalign    <= misalign | (next_pc[1:0] != 2'b00);
            end
        end
    end

    // The low address bits are dropped on load; misalign records that they were set.
    pc_register #(
        .RESET_VAL(RESET_PC)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    ({next_pc[WORD_W-1:2], 2'b00}),
        .q    (pc)
    );

    assign npc_plus4   = pc + PC_STEP;
    assign imem_addr   = pc;
    assign imem_req    = (state == ST_REQ);
    assign instr_valid = (state == ST_HOLD);
    assign halted      = (state == ST_HALTED);
    assign fsm_state   = state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a random
// wait-state/branch run, with fetched words checked through an expected queue.
module tb_pc_fetch_sequencer;
    import miniRISC_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] npc_plus4, next_pc, imem_addr, imem_data, instr, fetch_count;
    logic        imem_req, imem_rdy, instr_valid, instr_accept, halt, halted, misalign;
    logic [1:0]  fsm_state;

    logic        br_sel;
    logic [31:0] br_target;
    logic        use_fixed;
    logic [31:0] fixed_data;

    // external next-PC mux and instruction memory model
    assign next_pc   = br_sel ? br_target : npc_plus4;
    assign imem_data = use_fixed ? fixed_data : (imem_addr ^ 32'hA5A5_0000);

    pc_fetch_sequencer dut (
        .clk(clk), .rst(rst), .npc_plus4(npc_plus4), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
        .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
        .instr_accept(instr_accept), .halt(halt), .halted(halted),
        .misalign(misalign), .fetch_count(fetch_count), .fsm_state(fsm_state)
    );

    // second instance exercising a wrapping reset vector
    logic        w_rst, w_req, w_rdy, w_valid, w_accept, w_halted, w_misalign;
    logic [31:0] w_npc, w_addr, w_instr, w_count;
    logic [1:0]  w_state;

    pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(w_rst), .npc_plus4(w_npc), .next_pc(w_npc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdy(w_rdy),
        .imem_data(32'h1234_5678), .instr(w_instr), .instr_valid(w_valid),
        .instr_accept(w_accept), .halt(1'b0), .halted(w_halted),
        .misalign(w_misalign), .fetch_count(w_count), .fsm_state(w_state)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(negedge clk) begin
        if (!rst && instr_valid && instr_accept) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_instr: got %h with nothing expected", instr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (instr !== e) begin
                    miscompares++;
                    $display("FAIL sb_instr: got %h want %h", instr, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic halt_v);
        rst = 1'b1; imem_rdy = 1'b0; instr_accept = 1'b0; halt = halt_v;
        br_sel = 1'b0; br_target = '0; use_fixed = 1'b0; fixed_data = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // called in a REQ cycle: memory answers now, returns in the HOLD cycle
    task automatic issue(input logic [31:0] pc_model);
        imem_rdy = 1'b1;
        exp_q.push_back(use_fixed ? fixed_data : word_at(pc_model));
        tick();
        imem_rdy = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(1'b0);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        vectors++; if (npc_plus4 !== 32'h4) begin miscompares++; $display("FAIL rst_npc: got %h want 4", npc_plus4); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h want 0", instr); end
        vectors++; if ({halted, misalign} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b want 00", {halted, misalign}); end
        vectors++; if (fetch_count !== 32'h0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", fetch_count); end
        vectors++; if (fsm_state !== ST_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want %0d", fsm_state, ST_IDLE); end
        tick();
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL idle_one_cycle: req got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] pc;
        do_reset(1'b0);
        tick();
        instr_accept = 1'b1;
        pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (imem_req !== 1'b1 || imem_addr !== pc) begin miscompares++; $display("FAIL seq_addr%0d: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, pc); end
            issue(pc);
            vectors++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL seq_hold%0d: got valid=%b req=%b want 1 0", i, instr_valid, imem_req); end
            tick();
            pc = pc + 32'd4;
        end
        vectors++; if (fetch_count !== 32'd4) begin miscompares++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
        vectors++; if (imem_addr !== 32'h10 || npc_plus4 !== 32'h14) begin miscompares++; $display("FAIL seq_pc: got addr=%h npc=%h want 10 14", imem_addr, npc_plus4); end
        instr_accept = 1'b0;
    endtask

    task automatic test_branch_misalign();
        do_reset(1'b0);
        tick();
        instr_accept = 1'b1;
        issue(32'h0); tick();
        issue(32'h4); tick();
        issue(32'h8);
        vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("FAIL br_hold_pc: got %h want 8", imem_addr); end
        br_sel = 1'b1; br_target = 32'h40;
        tick();
        br_sel = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin miscompares++; $display("FAIL br_target: got req=%b addr=%h want 1 40", imem_req, imem_addr); end
        vectors++; if (misalign !== 1'b0 || fetch_count !== 32'd3) begin miscompares++; $display("FAIL br_flags: got mis=%b cnt=%0d want 0 3", misalign, fetch_count); end
        issue(32'h40);
        br_sel = 1'b1; br_target = 32'h43;
        tick();
        br_sel = 1'b0;
        vectors++; if (imem_addr !== 32'h40 || misalign !== 1'b1) begin miscompares++; $display("FAIL mis_load: got addr=%h mis=%b want 40 1", imem_addr, misalign); end
        issue(32'h40);
        tick();
        vectors++; if (imem_addr !== 32'h44 || misalign !== 1'b1) begin miscompares++; $display("FAIL mis_sticky: got addr=%h mis=%b want 44 1", imem_addr, misalign); end
        instr_accept = 1'b0;
        do_reset(1'b0);
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL mis_clear: got %b want 0", misalign); end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        tick();
        use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL stall_wait%0d: got req=%b valid=%b want 1 0", i, imem_req, instr_valid); end
            tick();
        end
        issue(32'h0);
        for (int i = 0; i < 3; i++) begin
            fixed_data = $urandom;
            vectors++; if (instr !== 32'hDEAD_BEEF || instr_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold%0d: got instr=%h valid=%b want deadbeef 1", i, instr, instr_valid); end
            tick();
        end
        instr_accept = 1'b1;
        tick();
        instr_accept = 1'b0;
        use_fixed = 1'b0;
        vectors++; if (fetch_count !== 32'd1 || imem_addr !== 32'h4 || imem_req !== 1'b1) begin miscompares++; $display("FAIL stall_done: got cnt=%0d addr=%h req=%b want 1 4 1", fetch_count, imem_addr, imem_req); end
    endtask

    task automatic test_halt();
        do_reset(1'b0);
        tick();
        halt = 1'b1;
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL halt_req_kept: got %b want 1", imem_req); end
        issue(32'h0);
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL halt_hold: got %b want 1", instr_valid); end
        instr_accept = 1'b1;
        tick();
        instr_accept = 1'b0;
        vectors++; if (halted !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_enter: got halted=%b req=%b want 1 0", halted, imem_req); end
        vectors++; if (fetch_count !== 32'd1 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL halt_accept: got cnt=%0d addr=%h want 1 4", fetch_count, imem_addr); end
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        vectors++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_park: got halted=%b req=%b valid=%b want 1 0 0", halted, imem_req, instr_valid); end
        halt = 1'b0;
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || halted !== 1'b0) begin miscompares++; $display("FAIL halt_resume: got req=%b addr=%h halted=%b want 1 4 0", imem_req, imem_addr, halted); end
        do_reset(1'b1);
        tick();
        vectors++; if (halted !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_from_idle: got halted=%b req=%b want 1 0", halted, imem_req); end
        halt = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc, tgt;
        int d, a, take;
        do_reset(1'b0);
        tick();
        pc = 32'h0;
        for (int i = 0; i < 20; i++) begin
            vectors++; if (imem_req !== 1'b1 || imem_addr !== pc) begin miscompares++; $display("FAIL rnd_addr%0d: got req=%b addr=%h want 1 %h", i, imem_req, imem_addr, pc); end
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) tick();
            issue(pc);
            a = $urandom_range(0, 2);
            for (int k = 0; k < a; k++) tick();
            take = $urandom_range(0, 1);
            tgt = $urandom & 32'hFFFF_FFFC;
            br_sel = (take != 0); br_target = tgt; instr_accept = 1'b1;
            tick();
            instr_accept = 1'b0; br_sel = 1'b0;
            pc = (take != 0) ? tgt : pc + 32'd4;
        end
        vectors++; if (fetch_count !== 32'd20 || misalign !== 1'b0) begin miscompares++; $display("FAIL rnd_count: got cnt=%0d mis=%b want 20 0", fetch_count, misalign); end
    endtask

    task automatic test_wrap_reset();
        w_rst = 1'b1; w_rdy = 1'b0; w_accept = 1'b0;
        tick();
        vectors++; if (w_npc !== 32'h0 || w_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_npc: got npc=%h addr=%h want 0 fffffffc", w_npc, w_addr); end
        w_rst = 1'b0;
        tick();
        vectors++; if (w_req !== 1'b1) begin miscompares++; $display("FAIL wrap_req: got %b want 1", w_req); end
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0; w_rdy = 1'b1;
        tick();
        vectors++; if (w_valid !== 1'b0 || w_addr !== 32'hFFFF_FFFC || w_req !== 1'b1) begin miscompares++; $display("FAIL wrap_drop: got valid=%b addr=%h req=%b want 0 fffffffc 1", w_valid, w_addr, w_req); end
        tick();
        w_rdy = 1'b0;
        vectors++; if (w_valid !== 1'b1 || w_instr !== 32'h1234_5678) begin miscompares++; $display("FAIL wrap_fetch: got valid=%b instr=%h want 1 12345678", w_valid, w_instr); end
        w_accept = 1'b1;
        tick();
        w_accept = 1'b0;
        vectors++; if (w_addr !== 32'h0 || w_count !== 32'd1) begin miscompares++; $display("FAIL wrap_pc: got addr=%h cnt=%0d want 0 1", w_addr, w_count); end
    endtask

    initial begin
        w_rst = 1'b1; w_rdy = 1'b0; w_accept = 1'b0;
        test_reset();
        test_sequential();
        test_branch_misalign();
        test_stall();
        test_halt();
        test_back_to_back();
        test_wrap_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
